// File: rtl/sn_pkg.sv
// Shared stochastic-number definitions: FSM states, bit-operation modes,
// default window length and the mode-dependent bit operation.
package sn_pkg;

  // Default number of valid stochastic samples per conversion window.
  localparam int SN_WIN_LEN = 16;

  // Converter control states. Encoding 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    SN_ST_IDLE = 2'd0,
    SN_ST_ACC  = 2'd1,
    SN_ST_DONE = 2'd2
  } sn_state_e;

  // Bit-operation mode applied to the incoming stochastic streams.
  typedef logic [1:0] sn_mode_t;

  localparam sn_mode_t SN_MODE_PASS     = 2'd0;  // pass A
  localparam sn_mode_t SN_MODE_AND      = 2'd1;  // unipolar multiply
  localparam sn_mode_t SN_MODE_XNOR     = 2'd2;  // bipolar multiply
  localparam sn_mode_t SN_MODE_PASS_ALT = 2'd3;  // pass A (alias)

  // Stochastic-domain bit operation; unknown/alias modes fall back to pass A.
  function automatic logic sn_apply_op(input sn_mode_t mode,
                                       input logic     a,
                                       input logic     b);
    logic r;
    case (mode)
      SN_MODE_AND:  r = a & b;
      SN_MODE_XNOR: r = ~(a ^ b);
      default:      r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sn_to_bn_if.sv
// Handshake/data bundle between a stochastic source/consumer and sn_to_bn.
interface sn_to_bn_if #(
  parameter int CNT_W = 5
);
  import sn_pkg::*;

  logic             i_start;
  logic             i_stop;
  sn_mode_t         i_mode;
  logic             i_sn_a;
  logic             i_sn_b;
  logic             i_sn_valid;
  logic             i_ready;
  logic [CNT_W-1:0] o_count;
  logic             o_valid;
  logic             o_busy;

  // Side that feeds streams/control and consumes the result.
  modport master (
    output i_start, i_stop, i_mode, i_sn_a, i_sn_b, i_sn_valid, i_ready,
    input  o_count, o_valid, o_busy
  );

  // Converter side.
  modport slave (
    input  i_start, i_stop, i_mode, i_sn_a, i_sn_b, i_sn_valid, i_ready,
    output o_count, o_valid, o_busy
  );

endinterface

// File: rtl/sn_bit_op.sv
// Combinational stochastic bit operation selected by mode.
module sn_bit_op
  import sn_pkg::*;
(
  input  sn_mode_t i_mode,
  input  logic     i_a,
  input  logic     i_b,
  output logic     o_bit
);

  assign o_bit = sn_apply_op(i_mode, i_a, i_b);

endmodule

// File: rtl/sn_to_bn.sv
// Stochastic-to-binary converter: counts ones of the processed stream over a
// window of WIN_LEN valid samples and offers the count with a valid/ready
// handshake. All outputs come straight from registers or state decode.
module sn_to_bn
  import sn_pkg::*;
#(
  parameter int WIN_LEN = SN_WIN_LEN,
  parameter int CNT_W   = $clog2(WIN_LEN) + 1
) (
  input  logic       i_clk_sng,
  input  logic       i_rst_sng,
  sn_to_bn_if.slave  bus
);

  // Counter value seen on the sample that completes the window.
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(WIN_LEN - 1);

  sn_state_e        state_q, state_d;
  sn_mode_t         mode_q,  mode_d;
  logic [CNT_W-1:0] acc_q,   acc_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;

  logic             proc_bit;
  logic             sample_ok;
  logic             last_sample;
  logic [CNT_W-1:0] acc_inc;

  // Bit operation always uses the mode latched at start, never the live input.
  sn_bit_op u_bit_op (
    .i_mode (mode_q),
    .i_a    (bus.i_sn_a),
    .i_b    (bus.i_sn_b),
    .o_bit  (proc_bit)
  );

  assign sample_ok   = (state_q == SN_ST_ACC) && bus.i_sn_valid;
  assign last_sample = sample_ok && (cnt_q == LAST_SAMPLE);
  assign acc_inc     = acc_q + {{(CNT_W-1){1'b0}}, proc_bit};

  // State and datapath registers; reset discards any window in flight.
  always_ff @(posedge i_clk_sng or posedge i_rst_sng) begin
    if (i_rst_sng) begin
      state_q <= SN_ST_IDLE;
      mode_q  <= SN_MODE_PASS;
      acc_q   <= '0;
      cnt_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic; stop takes priority over a completing sample.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SN_ST_IDLE: begin
        if (bus.i_start) state_d = SN_ST_ACC;
      end
      SN_ST_ACC: begin
        if (bus.i_stop)       state_d = SN_ST_IDLE;
        else if (last_sample) state_d = SN_ST_DONE;
      end
      SN_ST_DONE: begin
        if (bus.i_ready) state_d = SN_ST_IDLE;
      end
      default: state_d = SN_ST_IDLE;
    endcase
  end

  // Accumulator, sample counter, mode latch and result register updates.
  always_comb begin
    mode_d  = mode_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    valid_d = valid_q;
    case (state_q)
      SN_ST_IDLE: begin
        if (bus.i_start) begin
          mode_d = bus.i_mode;
          acc_d  = '0;
          cnt_d  = '0;
        end
      end
      SN_ST_ACC: begin
        if (bus.i_stop) begin
          // Abort: drop the partial sum, keep the previous result untouched.
          acc_d = '0;
          cnt_d = '0;
        end else if (sample_ok) begin
          acc_d = acc_inc;
          cnt_d = cnt_q + 1'b1;
          if (last_sample) begin
            count_d = acc_inc;
            valid_d = 1'b1;
          end
        end
      end
      SN_ST_DONE: begin
        if (bus.i_ready) valid_d = 1'b0;
      end
      default: begin
        acc_d   = '0;
        cnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Outputs are register copies and a state decode only.
  always_comb begin
    bus.o_count = count_q;
    bus.o_valid = valid_q;
    bus.o_busy  = (state_q != SN_ST_IDLE);
  end

endmodule

// File: tb/tb_sn_to_bn.sv
// Self-checking bench for sn_to_bn with a queue-based window reference model.
module tb_sn_to_bn;
  import sn_pkg::*;

  localparam int WIN = 16;
  localparam int CW  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sn_to_bn_if #(.CNT_W(CW)) bus ();

  sn_to_bn #(.WIN_LEN(WIN), .CNT_W(CW)) dut (
    .i_clk_sng (clk),
    .i_rst_sng (rst),
    .bus       (bus.slave)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int last_count = 0;

  // Stimulus for one window, one entry per ACC cycle.
  bit sa[$];
  bit sb[$];
  bit sv[$];

  // Reference: count processed ones over the first WIN valid samples.
  function automatic void model(input int mode, output int cnt, output int done_idx);
    int n;
    bit pb;
    cnt = 0; n = 0; done_idx = -1;
    for (int i = 0; i < sa.size(); i++) begin
      if (done_idx < 0 && sv[i]) begin
        case (mode)
          1:       pb = sa[i] & sb[i];
          2:       pb = (sa[i] == sb[i]);
          default: pb = sa[i];
        endcase
        cnt += int'(pb);
        n++;
        if (n == WIN) done_idx = i;
      end
    end
  endfunction

  task automatic clear_stim();
    sa.delete(); sb.delete(); sv.delete();
  endtask

  task automatic idle_inputs();
    bus.i_start = 0; bus.i_stop = 0; bus.i_mode = 2'd0;
    bus.i_sn_a = 0; bus.i_sn_b = 0; bus.i_sn_valid = 0; bus.i_ready = 0;
  endtask

  // Start cycle carries a valid all-ones sample that must not be counted.
  task automatic do_start(input int mode);
    bus.i_start = 1; bus.i_mode = 2'(mode);
    bus.i_sn_a = 1; bus.i_sn_b = 1; bus.i_sn_valid = 1;
    @(posedge clk); #1;
    bus.i_start = 0; bus.i_sn_valid = 0;
  endtask

  task automatic run_acc(input bit scramble, output int rise_idx);
    rise_idx = -1;
    for (int i = 0; i < sa.size(); i++) begin
      bus.i_sn_a = sa[i]; bus.i_sn_b = sb[i]; bus.i_sn_valid = sv[i];
      if (scramble) bus.i_mode = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      if (bus.o_valid === 1'b1 && rise_idx < 0) rise_idx = i;
    end
    bus.i_sn_valid = 0;
  endtask

  task automatic consume();
    bus.i_ready = 1;
    @(posedge clk); #1;
    bus.i_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.o_count !== 5'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", bus.o_count); end
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", bus.o_valid); end
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", bus.o_busy); end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_mode_pass();
    int e, idx, r;
    clear_stim();
    for (int i = 0; i < WIN + 2; i++) begin
      sa.push_back(((i * 5 + 3) % 16) < 11);
      sb.push_back(1'($urandom_range(0, 1)));
      sv.push_back(1'b1);
    end
    model(0, e, idx);
    do_start(0);
    n_cmp++; if (bus.o_busy !== 1'b1) begin n_bad++; $display("FAIL pass_busy_acc: got %b expected 1", bus.o_busy); end
    run_acc(0, r);
    n_cmp++; if (bus.o_count !== CW'(e)) begin n_bad++; $display("FAIL pass_count: got %0d expected %0d", bus.o_count, e); end
    n_cmp++; if (r != idx) begin n_bad++; $display("FAIL pass_latency: got %0d expected %0d", r, idx); end
    n_cmp++; if (bus.o_valid !== 1'b1) begin n_bad++; $display("FAIL pass_valid: got %b expected 1", bus.o_valid); end
    n_cmp++; if (bus.o_busy !== 1'b1) begin n_bad++; $display("FAIL pass_busy_done: got %b expected 1", bus.o_busy); end
    consume();
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL pass_consumed_valid: got %b expected 0", bus.o_valid); end
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL pass_consumed_busy: got %b expected 0", bus.o_busy); end
    last_count = e;
  endtask

  task automatic test_mode_and();
    int e, idx, r, j;
    bit tmp;
    clear_stim();
    for (int i = 0; i < WIN; i++) begin
      sa.push_back(1'b1); sb.push_back(i < 6); sv.push_back(1'b1);
    end
    for (int i = WIN - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = sb[i]; sb[i] = sb[j]; sb[j] = tmp;
    end
    model(1, e, idx);
    do_start(1);
    run_acc(0, r);
    n_cmp++; if (bus.o_count !== CW'(e)) begin n_bad++; $display("FAIL and_count: got %0d expected %0d", bus.o_count, e); end
    n_cmp++; if (r != idx) begin n_bad++; $display("FAIL and_latency: got %0d expected %0d", r, idx); end
    consume();
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL and_consumed: got %b expected 0", bus.o_valid); end
    last_count = e;
  endtask

  // Live mode is scrambled during ACC; only the latched mode may matter.
  task automatic test_mode_xnor();
    int e, idx, r;
    clear_stim();
    for (int i = 0; i < WIN; i++) begin
      sa.push_back(1'($urandom_range(0, 1)));
      sb.push_back(sa[i]);
      sv.push_back(1'b1);
    end
    model(2, e, idx);
    do_start(2);
    run_acc(1, r);
    n_cmp++; if (bus.o_count !== CW'(e)) begin n_bad++; $display("FAIL xnor_count: got %0d expected %0d", bus.o_count, e); end
    n_cmp++; if (r != idx) begin n_bad++; $display("FAIL xnor_latency: got %0d expected %0d", r, idx); end
    consume();
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL xnor_consumed: got %b expected 0", bus.o_busy); end
    last_count = e;
  endtask

  task automatic test_valid_toggle();
    int e, idx, r;
    for (int pass = 0; pass < 2; pass++) begin
      clear_stim();
      for (int i = 0; i < 2 * WIN + 2; i++) begin
        sa.push_back(pass == 0); sb.push_back(1'b0); sv.push_back(i % 2 == 1);
      end
      model(0, e, idx);
      do_start(0);
      run_acc(0, r);
      n_cmp++; if (bus.o_count !== CW'(e)) begin n_bad++; $display("FAIL toggle_count_%0d: got %0d expected %0d", pass, bus.o_count, e); end
      n_cmp++; if (r != idx) begin n_bad++; $display("FAIL toggle_latency_%0d: got %0d expected %0d", pass, r, idx); end
      consume();
      n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL toggle_consumed_%0d: got %b expected 0", pass, bus.o_valid); end
      last_count = e;
    end
  endtask

  task automatic test_random();
    int e, idx, r, mode, p, nv;
    for (int it = 0; it < 20; it++) begin
      clear_stim();
      mode = $urandom_range(0, 3);
      p = $urandom_range(1, 4);
      nv = 0;
      while (nv < WIN + 3) begin
        sa.push_back(1'($urandom_range(0, 1)));
        sb.push_back(1'($urandom_range(0, 1)));
        sv.push_back($urandom_range(1, 4) <= p);
        if (sv[sv.size() - 1]) nv++;
      end
      model(mode, e, idx);
      do_start(mode);
      run_acc(1'($urandom_range(0, 1)), r);
      n_cmp++; if (bus.o_count !== CW'(e)) begin n_bad++; $display("FAIL rand_count_%0d: got %0d expected %0d (mode %0d)", it, bus.o_count, e, mode); end
      n_cmp++; if (r != idx) begin n_bad++; $display("FAIL rand_latency_%0d: got %0d expected %0d", it, r, idx); end
      consume();
      n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL rand_consumed_%0d: got %b expected 0", it, bus.o_valid); end
      last_count = e;
    end
  endtask

  task automatic test_done_hold();
    int e, idx, r;
    clear_stim();
    for (int i = 0; i < WIN; i++) begin
      sa.push_back(1'b1); sb.push_back(1'b0); sv.push_back(1'b1);
    end
    model(0, e, idx);
    do_start(0);
    run_acc(0, r);
    for (int k = 0; k < 5; k++) begin
      bus.i_start = 1; bus.i_stop = 1;
      @(posedge clk); #1;
      n_cmp++; if (bus.o_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid_%0d: got %b expected 1", k, bus.o_valid); end
      n_cmp++; if (bus.o_count !== CW'(e)) begin n_bad++; $display("FAIL hold_count_%0d: got %0d expected %0d", k, bus.o_count, e); end
      n_cmp++; if (bus.o_busy !== 1'b1) begin n_bad++; $display("FAIL hold_busy_%0d: got %b expected 1", k, bus.o_busy); end
    end
    bus.i_start = 0; bus.i_stop = 0;
    consume();
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL hold_release_valid: got %b expected 0", bus.o_valid); end
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL hold_release_busy: got %b expected 0", bus.o_busy); end
    last_count = e;
    do_start(0);
    n_cmp++; if (bus.o_busy !== 1'b1) begin n_bad++; $display("FAIL hold_restart_busy: got %b expected 1", bus.o_busy); end
    bus.i_stop = 1;
    @(posedge clk); #1;
    bus.i_stop = 0;
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL hold_abort_busy: got %b expected 0", bus.o_busy); end
    n_cmp++; if (bus.o_count !== CW'(last_count)) begin n_bad++; $display("FAIL hold_abort_count: got %0d expected %0d", bus.o_count, last_count); end
  endtask

  task automatic test_stop();
    int r;
    // Abort on the ninth sample.
    clear_stim();
    for (int i = 0; i < 8; i++) begin
      sa.push_back(1'($urandom_range(0, 1))); sb.push_back(1'b0); sv.push_back(1'b1);
    end
    do_start(0);
    run_acc(0, r);
    bus.i_sn_a = 1; bus.i_sn_valid = 1; bus.i_stop = 1;
    @(posedge clk); #1;
    bus.i_stop = 0; bus.i_sn_valid = 0;
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL stop9_busy: got %b expected 0", bus.o_busy); end
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL stop9_valid: got %b expected 0", bus.o_valid); end
    n_cmp++; if (bus.o_count !== CW'(last_count)) begin n_bad++; $display("FAIL stop9_count: got %0d expected %0d", bus.o_count, last_count); end
    // Stop coincident with the completing sample.
    clear_stim();
    for (int i = 0; i < WIN - 1; i++) begin
      sa.push_back(1'b0); sb.push_back(1'b0); sv.push_back(1'b1);
    end
    do_start(0);
    run_acc(0, r);
    bus.i_sn_a = 1; bus.i_sn_valid = 1; bus.i_stop = 1;
    @(posedge clk); #1;
    bus.i_stop = 0; bus.i_sn_valid = 0;
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL stop16_valid: got %b expected 0", bus.o_valid); end
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL stop16_busy: got %b expected 0", bus.o_busy); end
    n_cmp++; if (bus.o_count !== CW'(last_count)) begin n_bad++; $display("FAIL stop16_count: got %0d expected %0d", bus.o_count, last_count); end
    @(posedge clk); #1;
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL stop16_late_valid: got %b expected 0", bus.o_valid); end
  endtask

  task automatic test_async_reset();
    int e, idx, r;
    clear_stim();
    for (int i = 0; i < 6; i++) begin
      sa.push_back(1'b1); sb.push_back(1'b0); sv.push_back(1'b1);
    end
    do_start(0);
    run_acc(0, r);
    bus.i_sn_a = 1; bus.i_sn_valid = 1;
    @(posedge clk); #1;
    #2 rst = 1;
    #1;
    n_cmp++; if (bus.o_count !== 5'd0) begin n_bad++; $display("FAIL arst_count: got %0d expected 0", bus.o_count); end
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid: got %b expected 0", bus.o_valid); end
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL arst_busy: got %b expected 0", bus.o_busy); end
    rst = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL arst_quiet_%0d: got valid %b busy %b expected 0 0", k, bus.o_valid, bus.o_busy); end
    end
    bus.i_sn_valid = 0;
    clear_stim();
    for (int i = 0; i < WIN; i++) begin
      sa.push_back(1'($urandom_range(0, 1))); sb.push_back(1'($urandom_range(0, 1))); sv.push_back(1'b1);
    end
    model(1, e, idx);
    do_start(1);
    run_acc(0, r);
    n_cmp++; if (bus.o_count !== CW'(e)) begin n_bad++; $display("FAIL arst_fresh_count: got %0d expected %0d", bus.o_count, e); end
    n_cmp++; if (r != idx) begin n_bad++; $display("FAIL arst_fresh_latency: got %0d expected %0d", r, idx); end
    consume();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_mode_pass();
    test_mode_and();
    test_mode_xnor();
    test_valid_toggle();
    test_random();
    test_done_hold();
    test_stop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
